// File: rtl/cavlc_pkg.sv
// ============================================================================
// Module   : cavlc_pkg
// Desc     : Shared widths and FSM state encoding for the CAVLC block sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cavlc_pkg;

    localparam int NC_W   = 6;
    localparam int MAXC_W = 5;
    localparam int LEN_W  = 5;
    localparam int LVL_W  = 7;
    localparam int WIN_W  = 16;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/cavlc_blk_seq_if.sv
// ============================================================================
// Module   : cavlc_blk_seq_if
// Desc     : RBSP word stream and block descriptor handshakes of the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cavlc_blk_seq_if
    import cavlc_pkg::*;
#(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] s_word;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [NC_W-1:0]   d_nC;
    logic [MAXC_W-1:0] d_max;
    logic              d_valid;
    logic              d_ready;

    modport master (
        output s_word, s_valid, s_last, d_nC, d_max, d_valid,
        input  s_ready, d_ready
    );

    modport slave (
        input  s_word, s_valid, s_last, d_nC, d_max, d_valid,
        output s_ready, d_ready
    );
endinterface

`default_nettype wire

// File: rtl/cavlc_bitbuf.sv
// ============================================================================
// Module   : cavlc_bitbuf
// Desc     : MSB-first bit buffer: shift out len bits, append a word at the tail.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cavlc_bitbuf
    import cavlc_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BUF_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] word,
    input  logic              pop,
    input  logic [LEN_W-1:0]  len,
    output logic [LVL_W-1:0]  level,
    output logic [WIN_W-1:0]  head,
    output logic              underrun
);

    // Bits at and beyond the fill level are kept zero, so the head window
    // is naturally zero-padded and shifting never drags stale data in.
    logic [BUF_W-1:0] bits_q, bits_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] len_ext;
    logic [LVL_W-1:0] lvl_shift;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] word_pos;

    always_comb begin
        len_ext   = LVL_W'(len);
        underrun  = pop && (len_ext > level_q);
        shifted   = bits_q;
        lvl_shift = level_q;
        if (pop) begin
            shifted   = bits_q << len;
            lvl_shift = underrun ? '0 : (level_q - len_ext);
        end
        // the new word lands right after the post-shift tail
        word_pos = {word, {(BUF_W-WORD_W){1'b0}}} >> lvl_shift;
        bits_d   = shifted;
        level_d  = lvl_shift;
        if (push) begin
            bits_d  = shifted | word_pos;
            level_d = lvl_shift + LVL_W'(WORD_W);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q  <= '0;
            level_q <= '0;
        end else begin
            bits_q  <= bits_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
    assign head  = bits_q[BUF_W-1 -: WIN_W];

endmodule

`default_nettype wire

// File: rtl/cavlc_blk_seq.sv
// ============================================================================
// Module   : cavlc_blk_seq
// Desc     : Block sequencer and bitstream feeder for the CAVLC residual decoder.
//            Define CAVLC_SEQ_BITCNT_EN to add the blk_bits per-block bit count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cavlc_blk_seq
    import cavlc_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BUF_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    cavlc_blk_seq_if.slave    bus,
    output logic              dec_ena,
    output logic              dec_start,
    output logic [WIN_W-1:0]  dec_rbsp,
    output logic [NC_W-1:0]   dec_nC,
    output logic [MAXC_W-1:0] dec_max,
    input  logic [LEN_W-1:0]  dec_len,
    input  logic              dec_idle,
    input  logic              dec_valid,
    output logic              blk_done,
    output logic [15:0]       blk_cnt,
    output logic              underflow,
    output logic [LVL_W-1:0]  level
`ifdef CAVLC_SEQ_BITCNT_EN
    ,
    output logic [9:0]        blk_bits
`endif
);

    seq_state_e        state_q, state_d;
    logic              eos_q, eos_d;
    logic [NC_W-1:0]   nc_q, nc_d;
    logic [MAXC_W-1:0] max_q, max_d;
    logic [15:0]       blk_cnt_q, blk_cnt_d;
    logic              underflow_q, underflow_d;

    logic [LVL_W-1:0]  lvl;
    logic              push;
    logic              pop;
    logic              underrun;
    logic              avail;
    logic              can_load;

    assign bus.s_ready = (lvl <= LVL_W'(BUF_W - WORD_W)) && !eos_q;
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = dec_ena && !dec_idle;
    assign avail       = (lvl >= LVL_W'(WIN_W)) || eos_q;
    // an exhausted stream must not launch another block
    assign can_load    = (lvl >= LVL_W'(WIN_W)) || (eos_q && (lvl != '0));

    cavlc_bitbuf #(
        .WORD_W (WORD_W),
        .BUF_W  (BUF_W)
    ) u_bitbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .word     (bus.s_word),
        .pop      (pop),
        .len      (dec_len),
        .level    (lvl),
        .head     (dec_rbsp),
        .underrun (underrun)
    );

    always_comb begin
        state_d     = state_q;
        nc_d        = nc_q;
        max_d       = max_q;
        blk_cnt_d   = blk_cnt_q;
        bus.d_ready = 1'b0;
        dec_start   = 1'b0;
        dec_ena     = 1'b0;
        blk_done    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (bus.d_valid && can_load) begin
                    bus.d_ready = 1'b1;
                    nc_d        = bus.d_nC;
                    max_d       = bus.d_max;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                dec_start = 1'b1;
                dec_ena   = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                dec_ena = avail;
                if (dec_valid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                blk_done  = 1'b1;
                blk_cnt_d = blk_cnt_q + 16'd1;
                state_d   = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        eos_d       = eos_q || (push && bus.s_last);
        underflow_d = underflow_q || underrun;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            eos_q       <= 1'b0;
            nc_q        <= '0;
            max_q       <= '0;
            blk_cnt_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            eos_q       <= eos_d;
            nc_q        <= nc_d;
            max_q       <= max_d;
            blk_cnt_q   <= blk_cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign dec_nC    = nc_q;
    assign dec_max   = max_q;
    assign blk_cnt   = blk_cnt_q;
    assign underflow = underflow_q;
    assign level     = lvl;

`ifdef CAVLC_SEQ_BITCNT_EN
    logic [9:0] bit_acc_q, bit_acc_d;
    logic [9:0] blk_bits_q, blk_bits_d;

    always_comb begin
        bit_acc_d  = bit_acc_q;
        blk_bits_d = blk_bits_q;
        if (state_q == ST_START) begin
            bit_acc_d = '0;
        end
        if (pop) begin
            bit_acc_d = bit_acc_d + 10'(dec_len);
        end
        if (state_q == ST_DONE) begin
            blk_bits_d = bit_acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_acc_q  <= '0;
            blk_bits_q <= '0;
        end else begin
            bit_acc_q  <= bit_acc_d;
            blk_bits_q <= blk_bits_d;
        end
    end

    assign blk_bits = blk_bits_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cavlc_blk_seq.sv
// ============================================================================
// Module   : tb_cavlc_blk_seq
// Desc     : Scoreboard bench for cavlc_blk_seq against a bit-queue stream model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cavlc_blk_seq;
    import cavlc_pkg::*;

    localparam int WORD_W = 32;
    localparam int BUF_W  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cavlc_blk_seq_if #(.WORD_W(WORD_W)) bus ();

    logic              dec_ena, dec_start, blk_done, underflow;
    logic              dec_idle, dec_valid;
    logic [15:0]       dec_rbsp, blk_cnt;
    logic [NC_W-1:0]   dec_nC;
    logic [MAXC_W-1:0] dec_max;
    logic [LEN_W-1:0]  dec_len;
    logic [LVL_W-1:0]  level;
`ifdef CAVLC_SEQ_BITCNT_EN
    logic [9:0]        blk_bits;
`endif

    cavlc_blk_seq #(.WORD_W(WORD_W), .BUF_W(BUF_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dec_ena   (dec_ena),
        .dec_start (dec_start),
        .dec_rbsp  (dec_rbsp),
        .dec_nC    (dec_nC),
        .dec_max   (dec_max),
        .dec_len   (dec_len),
        .dec_idle  (dec_idle),
        .dec_valid (dec_valid),
        .blk_done  (blk_done),
        .blk_cnt   (blk_cnt),
        .underflow (underflow),
        .level     (level)
`ifdef CAVLC_SEQ_BITCNT_EN
        ,
        .blk_bits  (blk_bits)
`endif
    );

    typedef struct {
        logic [NC_W-1:0]   nc;
        logic [MAXC_W-1:0] mx;
    } desc_t;

    int          total = 0;
    int          bad   = 0;
    desc_t       desc_q[$];
    desc_t       exp_q[$];
    logic [31:0] word_q[$];
    bit          last_q[$];
    bit          bits_m[$];
    bit          eos_m, uf_m, busy, fin_with_len, rand_gap;
    int          plan[$];
    int          lens_dir[$];
    int          n_start = 0;
    int          n_done  = 0;
    int          done_m  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] win16();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++)
            if (i < bits_m.size()) w[15-i] = bits_m[i];
        return w;
    endfunction

    // stream model + decoder model + stimulus drivers
    always @(negedge clk) begin
        int n;
        if (!rst_n) begin
            bits_m.delete();
            plan.delete();
            eos_m       = 0;
            uf_m        = 0;
            busy        = 0;
            dec_idle    = 1'b1;
            dec_len     = '0;
            dec_valid   = 1'b0;
            bus.s_valid = 1'b0;
            bus.s_word  = '0;
            bus.s_last  = 1'b0;
            bus.d_valid = 1'b0;
            bus.d_nC    = '0;
            bus.d_max   = '0;
        end else begin
            check("level", level, bits_m.size());
            check("rbsp", dec_rbsp, win16());
            check("underflow", underflow, uf_m);
            check("s_ready", bus.s_ready, (bits_m.size() <= BUF_W - WORD_W) && !eos_m);

            dec_valid = 1'b0;
            dec_len   = '0;
            dec_idle  = !busy;
            if (dec_start) begin
                busy     = 1;
                dec_idle = 1'b1;
                if (desc_q.size() != 0) void'(desc_q.pop_front());
                if (lens_dir.size() != 0) begin
                    plan = lens_dir;
                    lens_dir.delete();
                    fin_with_len = 1;
                end else begin
                    plan.delete();
                    repeat ($urandom_range(1, 6)) plan.push_back($urandom_range(0, 16));
                    fin_with_len = ($urandom_range(0, 1) == 1);
                end
            end else if (busy) begin
                dec_idle = 1'b0;
                if (dec_ena) begin
                    if (plan.size() == 0) begin
                        dec_valid = 1'b1;
                        busy      = 0;
                    end else begin
                        dec_len = 5'(plan.pop_front());
                        if (plan.size() == 0 && fin_with_len) begin
                            dec_valid = 1'b1;
                            busy      = 0;
                        end
                    end
                end else begin
                    dec_len = 5'($urandom_range(0, 16));
                end
            end

            if (dec_ena && !dec_idle) begin
                n = int'(dec_len);
                if (n > bits_m.size()) begin
                    uf_m = 1;
                    n    = bits_m.size();
                end
                repeat (n) void'(bits_m.pop_front());
            end

            bus.s_valid = 1'b0;
            if (word_q.size() != 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
                bus.s_valid = 1'b1;
                bus.s_word  = word_q[0];
                bus.s_last  = last_q[0];
                if (bus.s_ready) begin
                    for (int i = WORD_W - 1; i >= 0; i--) bits_m.push_back(word_q[0][i]);
                    if (last_q[0]) eos_m = 1;
                    void'(word_q.pop_front());
                    void'(last_q.pop_front());
                end
            end

            bus.d_valid = (desc_q.size() != 0);
            if (desc_q.size() != 0) begin
                bus.d_nC  = desc_q[0].nc;
                bus.d_max = desc_q[0].mx;
            end
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        desc_t e;
        if (!rst_n) begin
            done_m = 0;
        end else begin
            if (dec_start) begin
                n_start++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL start_unexpected: got start pulse, required none");
                end else begin
                    e = exp_q.pop_front();
                    check("start_nC", dec_nC, e.nc);
                    check("start_max", dec_max, e.mx);
                end
            end
            if (blk_done) begin
                n_done++;
                check("blk_cnt_at_done", blk_cnt, done_m);
                done_m++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_desc(input logic [NC_W-1:0] nc, input logic [MAXC_W-1:0] mx);
        desc_t d;
        d.nc = nc;
        d.mx = mx;
        desc_q.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic send_word(input logic [31:0] w, input bit last);
        word_q.push_back(w);
        last_q.push_back(last);
    endtask

    task automatic wait_done(input int budget, input string name);
        int s0;
        int k;
        s0 = n_done;
        k  = 0;
        while (n_done == s0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #2;
        check(name, (n_done != s0), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int k;
        rand_gap = 0;
        rst_n    = 1'b0;
        cyc(3);
        check("rst_level", level, 0);
        check("rst_dec_ena", dec_ena, 0);
        check("rst_dec_start", dec_start, 0);
        check("rst_blk_done", blk_done, 0);
        check("rst_blk_cnt", blk_cnt, 0);
        check("rst_underflow", underflow, 0);
        check("rst_d_ready", bus.d_ready, 0);
        check("rst_nC", dec_nC, 0);
        check("rst_max", dec_max, 0);
        rst_n = 1'b1;
        cyc(2);

        // single block consuming 5,7,4 from two words
        lens_dir = {5, 7, 4};
        send_desc(6'd0, 5'd16);
        send_word($urandom, 0);
        send_word($urandom, 0);
        wait_done(200, "t1_done");
        check("t1_level", level, 48);
        check("t1_blk_cnt", blk_cnt, 1);
        check("t1_starts", n_start, 1);
`ifdef CAVLC_SEQ_BITCNT_EN
        check("t1_blk_bits", blk_bits, 16);
`endif

        // drain to 8 bits, then a descriptor must wait for a word
        lens_dir = {16, 16, 8};
        send_desc(6'd2, 5'd15);
        wait_done(200, "t2a_done");
        check("t2_level", level, 8);
        lens_dir = {16, 8, 16, 4};
        send_desc(6'd3, 5'd16);
        s0 = n_start;
        cyc(6);
        check("t2_hold_d_ready", bus.d_ready, 0);
        check("t2_no_start", n_start, s0);
        send_word($urandom, 0);
        k = 0;
        while (n_start == s0 && k < 4) begin
            @(posedge clk);
            k++;
        end
        #2;
        check("t2_start_after_push", n_start, s0 + 1);

        // starvation inside RUN: ena drops at level 0 until a word arrives
        k = 0;
        while (level != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        #2;
        check("t3_level_zero", level, 0);
        for (int i = 0; i < 3; i++) begin
            check("t3_ena_stalled", dec_ena, 0);
            cyc(1);
        end
        send_word($urandom, 0);
        wait_done(100, "t3_done");
        check("t3_level", level, 28);
        check("t3_blk_cnt", blk_cnt, 3);

        // randomized blocks with gapped word delivery
        rand_gap = 1;
        repeat (150) send_word($urandom, 0);
        s0 = n_done;
        for (int i = 0; i < 30; i++) send_desc(6'($urandom), 5'($urandom));
        k = 0;
        while (n_done < s0 + 30 && k < 20000) begin
            @(posedge clk);
            k++;
        end
        #2;
        check("rand_blocks", n_done - s0, 30);
        check("rand_blk_cnt", blk_cnt, 33);

        // reset in the middle of a block
        repeat (20) lens_dir.push_back(1);
        send_desc(6'd1, 5'd4);
        k = 0;
        while (!busy && k < 50) begin
            @(posedge clk);
            k++;
        end
        cyc(3);
        rst_n = 1'b0;
        #1;
        check("t6_level", level, 0);
        check("t6_blk_cnt", blk_cnt, 0);
        check("t6_dec_ena", dec_ena, 0);
        check("t6_blk_done", blk_done, 0);
        check("t6_dec_start", dec_start, 0);
        word_q.delete();
        last_q.delete();
        desc_q.delete();
        exp_q.delete();
        lens_dir.delete();
        cyc(2);
        rst_n = 1'b1;
        s0 = n_done;
        cyc(5);
        check("t6_no_done", n_done, s0);
        check("t6_blk_cnt_after", blk_cnt, 0);

        // end of stream: zero padding, over-consumption, then LOAD hold
        lens_dir = {16, 10, 10};
        send_desc(6'h3f, 5'd4);
        send_word($urandom, 1);
        wait_done(100, "t5_done");
        check("t5_underflow", underflow, 1);
        check("t5_level", level, 0);
        check("t5_s_ready", bus.s_ready, 0);
        send_desc(6'd0, 5'd16);
        s0 = n_start;
        cyc(6);
        check("t5_hold_d_ready", bus.d_ready, 0);
        check("t5_no_start", n_start, s0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
